bram_tx_streamer: RTL

- Read side of the image buffer: on a start request, reads frame_len bytes from the block RAM, beginning at address 0 and going upward.
- Hands each byte to the UART Sender using a proper start/busy handshake: one byte per transaction, no drops, no duplicates.
- Sits in the top level between the BRAM read port and the Sender.
- Replaces the ad-hoc button-level transmit loop with a controlled frame streamer.

---
 rtl/img_pkg.sv | 20 ++
 rtl/edge_detect.sv | 29 ++
 rtl/bram_tx_streamer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared constants and types for the image buffer read/transmit path.
// Imported by the frame streamer and the BRAM controller so both sides agree
// on address width, byte width and buffer depth.
package img_pkg;

  localparam int unsigned IMG_ADDR_W = 13;
  localparam int unsigned IMG_DATA_W = 8;
  localparam int unsigned IMG_BYTES  = 8192;

  // Frame streamer states.
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } tx_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for already-synchronised level inputs
// (Transmit and Receive buttons).
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   sig_i  - level input
//   rise_o - high in the cycle where sig_i is 1 and was 0 the cycle before
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // The history register updates every cycle, so a level held high never
  // produces a second edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/bram_tx_streamer.sv
// Frame streamer: on a start edge, reads frame_len bytes from the image BRAM
// starting at address 0 and hands them one at a time to the UART Sender
// using a start/busy handshake.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   start          - level request; rising edge starts a frame
//   abort          - synchronous abort back to IDLE (no done pulse)
//   frame_len      - byte count 0..2**ADDR_W, sampled on the start edge
//   bram_en/addr   - BRAM read port request (one-cycle enable per byte)
//   bram_dout      - BRAM read data, valid RD_LAT cycles after bram_en
//   tx_start       - one-cycle pulse to the Sender
//   tx_data        - byte to the Sender, stable until the next read completes
//   tx_busy        - Sender busy
//   busy           - frame in progress
//   done           - one-cycle pulse after the last byte finished
//   last_byte      - last byte handed to the Sender
// All outputs are registered.
module bram_tx_streamer
  import img_pkg::*;
#(
  parameter int unsigned ADDR_W = IMG_ADDR_W,
  parameter int unsigned DATA_W = IMG_DATA_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ACK_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_byte
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned RDC_W = $clog2(RD_LAT + 1);
  localparam int unsigned ACK_W = $clog2(ACK_TO + 1);

  logic start_rise;

  tx_state_t         state_q,     state_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [LEN_W-1:0]  cnt_q,       cnt_d;
  logic [RDC_W-1:0]  rd_cnt_q,    rd_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q,   ack_cnt_d;
  logic              bram_en_q,   bram_en_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              tx_start_q,  tx_start_d;
  logic [DATA_W-1:0] tx_data_q,   tx_data_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [DATA_W-1:0] last_q,      last_d;

  edge_detect u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_d      = last_q;

    case (state_q)
      // DONE has busy=0 already, so it accepts a new edge exactly like IDLE.
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start_rise) begin
          if (frame_len == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            len_d       = frame_len;
            cnt_d       = '0;
            bram_addr_d = '0;
            bram_en_d   = 1'b1;
            rd_cnt_d    = '0;
            busy_d      = 1'b1;
            state_d     = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (rd_cnt_q == RDC_W'(RD_LAT)) begin
          tx_data_d = bram_dout;
          last_d    = bram_dout;
          // Pulse straight away when the Sender is idle so tx_start lines up
          // with the first cycle tx_data is valid.
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            ack_cnt_d  = '0;
            state_d    = WAIT_ACK;
          end else begin
            state_d = SEND;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + RDC_W'(1);
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          ack_cnt_d  = '0;
          state_d    = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
          // Sender never acknowledged; treat the byte as accepted.
          state_d = WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (cnt_q + LEN_W'(1) == len_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d       = cnt_q + LEN_W'(1);
            bram_addr_d = bram_addr_q + ADDR_W'(1);
            bram_en_d   = 1'b1;
            rd_cnt_d    = '0;
            state_d     = RD_WAIT;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      bram_en_d  = 1'b0;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      ack_cnt_q   <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_q      <= last_d;
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign last_byte = last_q;

endmodule
